// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
// The requester drives start and operands; the divider returns status and results.
interface seq_restoring_divider_if #(
  parameter int unsigned DIVIDEND_W = 8,
  parameter int unsigned DIVISOR_W  = 4
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
// A zero divisor finishes after a single busy cycle with quotient all ones and dbz set.
module seq_restoring_divider #(
  parameter int unsigned DIVIDEND_W = 8,
  parameter int unsigned DIVISOR_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_restoring_divider_if.slave  bus
);

  localparam int unsigned PR_W  = DIVISOR_W + 1;
  localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W-1:0]  pr_q, pr_d;
  logic [DIVIDEND_W-1:0] qacc_q, qacc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [PR_W-1:0]       pr_shift;
  logic                  qbit;
  logic [DIVIDEND_W-1:0] qacc_next;

  // All state, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      pr_q    <= '0;
      qacc_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      pr_q    <= pr_d;
      qacc_q  <= qacc_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, iteration datapath and registered-output next values
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    pr_d    = pr_q;
    qacc_d  = qacc_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    pr_shift  = {pr_q, dvd_q[DIVIDEND_W-1]};
    qbit      = (pr_shift >= PR_W'(dsr_q));
    qacc_next = (qacc_q << 1) | DIVIDEND_W'(qbit);

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          dvd_d   = bus.dividend;
          dsr_d   = bus.divisor;
          pr_d    = '0;
          qacc_d  = '0;
          cnt_d   = '0;
          quo_d   = '0;
          rem_d   = '0;
          dbz_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (dsr_q == '0) begin
          state_d = DONE;
          quo_d   = '1;
          rem_d   = '0;
          dbz_d   = 1'b1;
        end else begin
          // Restore by keeping the unsubtracted value when the trial subtraction would go negative
          pr_d   = qbit ? DIVISOR_W'(pr_shift - PR_W'(dsr_q)) : DIVISOR_W'(pr_shift);
          dvd_d  = dvd_q << 1;
          qacc_d = qacc_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
            state_d = DONE;
            quo_d   = qacc_next;
            rem_d   = pr_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases, handshake corners,
// randomized operations and an exhaustive operand sweep against an arithmetic model.
module tb_seq_restoring_divider;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  seq_restoring_divider_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) bus ();

  seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division, all-ones quotient on zero divisor
  function automatic void ref_div(input int a, input int b, output int q, output int r,
                                  output int z, output int lat);
    if (b == 0) begin
      q = 255; r = 0; z = 1; lat = 1;
    end else begin
      q = a / b; r = a % b; z = 0; lat = 8;
    end
  endfunction

  // Issue one accepted operation, scramble the operand inputs, wait for done
  task automatic do_op(input int a, input int b, output int lat, output int q,
                       output int r, output int z, output bit hold_ok, output int busy_at_done);
    bus.start    = 1'b1;
    bus.dividend = 8'(a);
    bus.divisor  = 4'(b);
    tick();
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
    hold_ok = (bus.busy === 1'b1) && (bus.done === 1'b0) && (bus.quotient === 8'd0)
              && (bus.remainder === 4'd0) && (bus.dbz === 1'b0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
      if (!((bus.busy === 1'b1) && (bus.quotient === 8'd0))) hold_ok = 1'b0;
    end
    q = int'(bus.quotient);
    r = int'(bus.remainder);
    z = int'(bus.dbz);
    busy_at_done = int'(bus.busy);
  endtask

  task automatic test_reset();
    bit quiet;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor = 4'd0;
    tick(); tick();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_tests++; if (bus.dbz !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", bus.dbz); end
    n_tests++; if (bus.quotient !== 8'd0) begin n_fail++; $display("FAIL reset_quotient: got %0d expected 0", bus.quotient); end
    n_tests++; if (bus.remainder !== 4'd0) begin n_fail++; $display("FAIL reset_remainder: got %0d expected 0", bus.remainder); end
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    n_tests++; if (!quiet) begin n_fail++; $display("FAIL reset_release_idle: got activity expected none"); end
  endtask

  task automatic test_directed();
    int va [6] = '{200, 255, 5, 0, 100, 100};
    int vb [6] = '{7, 15, 9, 3, 0, 10};
    int lat, q, r, z, bd, eq, er, ez, elat;
    bit hold;
    for (int k = 0; k < 6; k++) begin
      do_op(va[k], vb[k], lat, q, r, z, hold, bd);
      ref_div(va[k], vb[k], eq, er, ez, elat);
      n_tests++; if (lat != elat) begin n_fail++; $display("FAIL dir_latency %0d/%0d: got %0d expected %0d", va[k], vb[k], lat, elat); end
      n_tests++; if (q != eq) begin n_fail++; $display("FAIL dir_quotient %0d/%0d: got %0d expected %0d", va[k], vb[k], q, eq); end
      n_tests++; if (r != er) begin n_fail++; $display("FAIL dir_remainder %0d/%0d: got %0d expected %0d", va[k], vb[k], r, er); end
      n_tests++; if (z != ez) begin n_fail++; $display("FAIL dir_dbz %0d/%0d: got %0d expected %0d", va[k], vb[k], z, ez); end
      n_tests++; if (!hold) begin n_fail++; $display("FAIL dir_busy_hold %0d/%0d: got 0 expected 1", va[k], vb[k]); end
      n_tests++; if (bd != 0) begin n_fail++; $display("FAIL dir_busy_at_done %0d/%0d: got %0d expected 0", va[k], vb[k], bd); end
      tick();
      n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dir_done_pulse %0d/%0d: got %b expected 0", va[k], vb[k], bus.done); end
      n_tests++; if (bus.quotient !== 8'(eq)) begin n_fail++; $display("FAIL dir_quotient_held %0d/%0d: got %0d expected %0d", va[k], vb[k], bus.quotient, eq); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd3;
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int i = 4; i <= 20; i++) begin
      tick();
      if (bus.done === 1'b1) begin lat = i; break; end
    end
    n_tests++; if (lat != 8) begin n_fail++; $display("FAIL b2b_ignored_latency: got %0d expected 8", lat); end
    n_tests++; if (bus.quotient !== 8'd28) begin n_fail++; $display("FAIL b2b_ignored_quotient: got %0d expected 28", bus.quotient); end
    n_tests++; if (bus.remainder !== 4'd4) begin n_fail++; $display("FAIL b2b_ignored_remainder: got %0d expected 4", bus.remainder); end
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd3;
    tick();
    bus.start = 1'b0; bus.dividend = 8'd1; bus.divisor = 4'd1;
    n_tests++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done); end
    n_tests++; if (bus.quotient !== 8'd0) begin n_fail++; $display("FAIL b2b_clear: got %0d expected 0", bus.quotient); end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done === 1'b1) begin lat = i; break; end
    end
    n_tests++; if (lat != 8) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
    n_tests++; if (bus.quotient !== 8'd16) begin n_fail++; $display("FAIL b2b_quotient: got %0d expected 16", bus.quotient); end
    n_tests++; if (bus.remainder !== 4'd2) begin n_fail++; $display("FAIL b2b_remainder: got %0d expected 2", bus.remainder); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit quiet;
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    n_tests++; if (bus.quotient !== 8'd0) begin n_fail++; $display("FAIL midrst_quotient: got %0d expected 0", bus.quotient); end
    tick();
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    n_tests++; if (!quiet) begin n_fail++; $display("FAIL midrst_no_done: got activity expected none"); end
  endtask

  task automatic test_random();
    int a, b, lat, q, r, z, bd, eq, er, ez, elat;
    bit hold;
    for (int k = 0; k < 300; k++) begin
      a = int'($urandom_range(255, 0));
      b = int'($urandom_range(15, 0));
      do_op(a, b, lat, q, r, z, hold, bd);
      ref_div(a, b, eq, er, ez, elat);
      n_tests++;
      if (lat != elat || q != eq || r != er || z != ez || !hold || bd != 0) begin
        n_fail++;
        $display("FAIL rand %0d/%0d: got q=%0d r=%0d dbz=%0d lat=%0d hold=%0d busy=%0d expected q=%0d r=%0d dbz=%0d lat=%0d hold=1 busy=0",
                 a, b, q, r, z, lat, hold, bd, eq, er, ez, elat);
      end
      if (b != 0) begin
        n_tests++;
        if (q * b + r != a || r >= b) begin n_fail++; $display("FAIL rand_invariant %0d/%0d: got q=%0d r=%0d expected q*d+r=a, r<d", a, b, q, r); end
      end
      if ($urandom_range(1, 0) == 1) tick();
    end
    tick();
  endtask

  task automatic test_sweep();
    int lat, q, r, z, bd, eq, er, ez, elat;
    bit hold;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(a, b, lat, q, r, z, hold, bd);
        ref_div(a, b, eq, er, ez, elat);
        tick();
        n_tests++;
        if (lat != elat || q != eq || r != er || z != ez || bus.done !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%0d lat=%0d done_after=%b expected q=%0d r=%0d dbz=%0d lat=%0d done_after=0",
                   a, b, q, r, z, lat, bus.done, eq, er, ez, elat);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor = 4'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
